// File: rtl/y86_alu.sv
// y86_alu: Y86-64 execute ALU with live combinational result/flags and a registered copy
module y86_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             sign,
  output logic [WIDTH-1:0] out_q,
  output logic             ovf_q,
  output logic             zero_q,
  output logic             sign_q
);
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  assign sub   = control == 2'b01;
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
  // SUB is a + ~b + 1, so both ops share one overflow rule on the effective operand
  always_comb begin
    out      = control == 2'b10 ? a & b : control == 2'b11 ? a ^ b : sum;
    overflow = !control[1] && (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    zero     = out == '0;
    sign     = out[WIDTH-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      out_q  <= out;
      ovf_q  <= overflow;
      zero_q <= zero;
      sign_q <= sign;
    end
  end
endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu: directed and randomized checks of y86_alu against a wide-arithmetic model
module tb_y86_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a = '0, b = '0;
  logic [1:0]  control = 2'b00;
  logic [63:0] out, out_q;
  logic        overflow, zero, sign, ovf_q, zero_q, sign_q;
  int          n_chk = 0, n_fail = 0;
  logic [63:0] edge_vals [8] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                                 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001,
                                 64'h7FFF_FFFF_FFFF_FFFE, 64'h1234};

  y86_alu #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .control(control),
    .out(out), .overflow(overflow), .zero(zero), .sign(sign),
    .out_q(out_q), .ovf_q(ovf_q), .zero_q(zero_q), .sign_q(sign_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // true result computed at 65 bits; overflow means it does not fit back into 64
  function automatic void model(input logic [63:0] x, input logic [63:0] y, input logic [1:0] c,
                                output logic [63:0] r, output logic v);
    logic signed [64:0] full;
    full = 65'sd0;
    v = 1'b0;
    case (c)
      2'b00: full = $signed({x[63], x}) + $signed({y[63], y});
      2'b01: full = $signed({x[63], x}) - $signed({y[63], y});
      2'b10: full = {1'b0, x & y};
      default: full = {1'b0, x ^ y};
    endcase
    r = full[63:0];
    if (!c[1]) v = full[64] != full[63];
  endfunction

  task automatic apply(input logic [63:0] x, input logic [63:0] y, input logic [1:0] c);
    logic [63:0] r;
    logic        v;
    a = x; b = y; control = c;
    model(x, y, c, r, v);
    #1;
    chk("out", out, r);
    chk("overflow", {63'd0, overflow}, {63'd0, v});
    chk("zero", {63'd0, zero}, {63'd0, r == 64'd0});
    chk("sign", {63'd0, sign}, {63'd0, r[63]});
    @(posedge clk); #1;
    chk("out_q", out_q, r);
    chk("ovf_q", {63'd0, ovf_q}, {63'd0, v});
    chk("zero_q", {63'd0, zero_q}, {63'd0, r == 64'd0});
    chk("sign_q", {63'd0, sign_q}, {63'd0, r[63]});
  endtask

  function automatic logic [63:0] pick();
    return ($urandom_range(3) == 0) ? edge_vals[$urandom_range(7)] : {$urandom, $urandom};
  endfunction

  initial begin
    #3;
    chk("rst out_q", out_q, 64'd0);
    chk("rst flags", {61'd0, ovf_q, zero_q, sign_q}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply(64'd5, 64'd7, 2'b00);
    chk("add 12", out, 64'd12);
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00);
    chk("max+1 ovf", {63'd0, overflow}, 64'd1);
    apply(64'h8000_0000_0000_0000, 64'd1, 2'b01);
    chk("min-1", out, 64'h7FFF_FFFF_FFFF_FFFF);
    apply(64'h10, 64'd1, 2'b01);
    chk("sub F", out, 64'hF);
    apply(64'd0, 64'h8000_0000_0000_0000, 2'b01);
    chk("0-min ovf", {63'd0, overflow}, 64'd1);
    apply(64'hF0F0, 64'hFF00, 2'b10);
    chk("and", out, 64'hF000);
    apply(64'hF0F0, 64'hFF00, 2'b11);
    chk("xor", out, 64'h0FF0);
    apply(64'h1234, 64'h1234, 2'b01);
    chk("x-x zero", {63'd0, zero}, 64'd1);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
    chk("xor zero", {63'd0, zero}, 64'd1);
    // async reset mid-cycle clears the copy while the combinational path stays live
    apply(64'd5, 64'd7, 2'b00);
    #2 rst = 1'b1;
    #1;
    chk("async out_q", out_q, 64'd0);
    chk("async flags", {61'd0, ovf_q, zero_q, sign_q}, 64'd0);
    chk("live out", out, 64'd12);
    @(posedge clk); #1;
    chk("held out_q", out_q, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reload out_q", out_q, 64'd12);
    for (int i = 0; i < 300; i++) apply(pick(), pick(), 2'($urandom_range(3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
